ysyx_24070017_rf_mp: RTL and testbench

Parametrised multi-ported general-purpose register file for the NPC core, the successor to the single flat-vector RF. It replaces per-register write enables with addressed read and write ports, and adds optional write-to-read bypass and a per-register busy scoreboard. The scoreboard lets the issue stage detect RAW hazards against in-flight writebacks. It sits between decode/issue (read ports, busy set) and writeback (write ports, busy clear).

---
 rtl/ysyx_24070017_rf_mp.sv | 110 +++++++++++
 tb/tb_ysyx_24070017_rf_mp.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24070017_rf_mp.sv
// ysyx_24070017_rf_mp: multi-ported general-purpose register file for the NPC core.
// It provides addressed read and write ports and optional write-to-read forwarding.
// It also keeps a per-register busy scoreboard that the issue stage uses to detect
// RAW hazards against writebacks that are still in flight.
module ysyx_24070017_rf_mp #(
    parameter int WORD_LENGTH = 32,
    parameter int REG_NUM     = 32,
    parameter int ADDR_W      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1,
    parameter int NR_READ     = 2,
    parameter int NR_WRITE    = 1,
    parameter bit BYPASS      = 1'b1,
    parameter bit ZERO_REG    = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NR_READ*ADDR_W-1:0]       raddr,
    output logic [NR_READ*WORD_LENGTH-1:0]  rdata,
    output logic [NR_READ-1:0]              rbusy,
    input  logic [NR_WRITE-1:0]             wen,
    input  logic [NR_WRITE*ADDR_W-1:0]      waddr,
    input  logic [NR_WRITE*WORD_LENGTH-1:0] wdata,
    input  logic                            set_en,
    input  logic [ADDR_W-1:0]               set_addr,
    output logic [REG_NUM-1:0]              busy
);

    // Lowest register that has storage. With ZERO_REG, x0 is a constant and has no flops.
    localparam int FIRST = ZERO_REG ? 1 : 0;

    logic [WORD_LENGTH-1:0] regs   [FIRST:REG_NUM-1];
    logic                   wr_hit [FIRST:REG_NUM-1];
    logic [WORD_LENGTH-1:0] wr_val [FIRST:REG_NUM-1];
    logic [REG_NUM-1:0]     busy_q;

    // Resolve all write ports per register. A later (higher-index) port overrides
    // an earlier one. Invalid addresses and x0 never match a stored register.
    // Reset suppresses every write.
    always_comb begin
        for (int i = FIRST; i < REG_NUM; i++) begin
            // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
            wr_hit[i] = 1'b0;
            wr_val[i] = '0;
            for (int k = 0; k < NR_WRITE; k++) begin
                if (!rst && wen[k] && waddr[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    wr_hit[i] = 1'b1;
                    wr_val[i] = wdata[k*WORD_LENGTH +: WORD_LENGTH];
                end
            end
        end
    end

    // Register storage: clear on reset, otherwise take the winning write.
    always_ff @(posedge clk) begin
        for (int i = FIRST; i < REG_NUM; i++) begin
            // NOTE: the array is cleared on reset because software expects zeroed
            // registers after rst. Non-blocking assignments keep every element
            // updating from pre-edge values.
            if (rst) begin
                regs[i] <= '0;
            end else if (wr_hit[i]) begin
                regs[i] <= wr_val[i];
            end
        end
    end

    // Scoreboard: a new issue (set) beats a completing writeback (clear) on the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            for (int i = FIRST; i < REG_NUM; i++) begin
                if (set_en && set_addr == ADDR_W'(i)) begin
                    busy_q[i] <= 1'b1;
                end else if (wr_hit[i]) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // Published scoreboard. With ZERO_REG, x0 is hard-wired not busy.
    always_comb begin
        busy = busy_q;
        if (ZERO_REG) begin
            busy[0] = 1'b0;
        end
    end

    // Read ports. An out-of-range address or x0 matches nothing and reads 0 / not busy.
    // When a same-cycle write hits the addressed register, its data is forwarded
    // and the register is reported as not busy.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int p = 0; p < NR_READ; p++) begin
            for (int i = FIRST; i < REG_NUM; i++) begin
                if (raddr[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
                    if (BYPASS && wr_hit[i]) begin
                        rdata[p*WORD_LENGTH +: WORD_LENGTH] = wr_val[i];
                        rbusy[p]                            = 1'b0;
                    end else begin
                        rdata[p*WORD_LENGTH +: WORD_LENGTH] = regs[i];
                        rbusy[p]                            = busy_q[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24070017_rf_mp.sv
// Testbench for ysyx_24070017_rf_mp. It drives two configurations side by side:
//   inst 0: REG_NUM=20 (non power of two), 3 read ports, 2 write ports, BYPASS=1, ZERO_REG=1
//   inst 1: REG_NUM=16 (RV32E), 2 read ports, 1 write port, BYPASS=0, ZERO_REG=0
// A behavioural register/scoreboard model predicts every output on every cycle.
module tb_ysyx_24070017_rf_mp;

    localparam int A_RN = 20, A_AW = 5, A_NR = 3, A_NW = 2;
    localparam int B_RN = 16, B_AW = 4, B_NR = 2, B_NW = 1;

    localparam int RN  [2] = '{A_RN, B_RN};
    localparam int AW  [2] = '{A_AW, B_AW};
    localparam int NR  [2] = '{A_NR, B_NR};
    localparam int NW  [2] = '{A_NW, B_NW};
    localparam bit BYP [2] = '{1'b1, 1'b0};
    localparam bit ZR  [2] = '{1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [A_NR*A_AW-1:0] a_raddr;
    logic [A_NR*32-1:0]   a_rdata;
    logic [A_NR-1:0]      a_rbusy;
    logic [A_NW-1:0]      a_wen;
    logic [A_NW*A_AW-1:0] a_waddr;
    logic [A_NW*32-1:0]   a_wdata;
    logic                 a_set_en;
    logic [A_AW-1:0]      a_set_addr;
    logic [A_RN-1:0]      a_busy;

    logic [B_NR*B_AW-1:0] b_raddr;
    logic [B_NR*32-1:0]   b_rdata;
    logic [B_NR-1:0]      b_rbusy;
    logic [B_NW-1:0]      b_wen;
    logic [B_NW*B_AW-1:0] b_waddr;
    logic [B_NW*32-1:0]   b_wdata;
    logic                 b_set_en;
    logic [B_AW-1:0]      b_set_addr;
    logic [B_RN-1:0]      b_busy;

    ysyx_24070017_rf_mp #(
        .WORD_LENGTH(32), .REG_NUM(A_RN), .NR_READ(A_NR), .NR_WRITE(A_NW),
        .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .raddr(a_raddr), .rdata(a_rdata), .rbusy(a_rbusy),
        .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata), .set_en(a_set_en),
        .set_addr(a_set_addr), .busy(a_busy)
    );

    ysyx_24070017_rf_mp #(
        .WORD_LENGTH(32), .REG_NUM(B_RN), .NR_READ(B_NR), .NR_WRITE(B_NW),
        .BYPASS(1'b0), .ZERO_REG(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .raddr(b_raddr), .rdata(b_rdata), .rbusy(b_rbusy),
        .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata), .set_en(b_set_en),
        .set_addr(b_set_addr), .busy(b_busy)
    );

    // Stimulus, per instance, as plain integers.
    int          s_raddr    [2][4];
    bit          s_wen      [2][2];
    int          s_waddr    [2][2];
    logic [31:0] s_wdata    [2][2];
    bit          s_set_en   [2];
    int          s_set_addr [2];
    bit          s_rst;

    // Reference model state.
    logic [31:0] mreg  [2][32];
    bit          mbusy [2][32];
    bit          mvalid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Pack the stimulus onto the DUT buses.
    always_comb begin
        rst        = s_rst;
        a_raddr    = '0;
        a_wen      = '0;
        a_waddr    = '0;
        a_wdata    = '0;
        b_raddr    = '0;
        b_wen      = '0;
        b_waddr    = '0;
        b_wdata    = '0;
        for (int p = 0; p < A_NR; p++) a_raddr[p*A_AW +: A_AW] = A_AW'(s_raddr[0][p]);
        for (int p = 0; p < B_NR; p++) b_raddr[p*B_AW +: B_AW] = B_AW'(s_raddr[1][p]);
        for (int k = 0; k < A_NW; k++) begin
            a_wen[k]              = s_wen[0][k];
            a_waddr[k*A_AW +: A_AW] = A_AW'(s_waddr[0][k]);
            a_wdata[k*32 +: 32]   = s_wdata[0][k];
        end
        for (int k = 0; k < B_NW; k++) begin
            b_wen[k]              = s_wen[1][k];
            b_waddr[k*B_AW +: B_AW] = B_AW'(s_waddr[1][k]);
            b_wdata[k*32 +: 32]   = s_wdata[1][k];
        end
        a_set_en   = s_set_en[0];
        a_set_addr = A_AW'(s_set_addr[0]);
        b_set_en   = s_set_en[1];
        b_set_addr = B_AW'(s_set_addr[1]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            for (int p = 0; p < 4; p++) s_raddr[n][p] = 0;
            for (int k = 0; k < 2; k++) begin
                s_wen[n][k]   = 1'b0;
                s_waddr[n][k] = 0;
                s_wdata[n][k] = '0;
            end
            s_set_en[n]   = 1'b0;
            s_set_addr[n] = 0;
        end
        s_rst = 1'b0;
    endtask

    // A write port commits when enabled, the address exists, it is not the constant x0,
    // and reset is low.
    function automatic bit commits(int n, int k);
        return k < NW[n] && s_wen[n][k] && !s_rst && s_waddr[n][k] < RN[n]
               && !(ZR[n] && s_waddr[n][k] == 0);
    endfunction

    function automatic logic [31:0] exp_rdata(int n, int p);
        int          ra = s_raddr[n][p];
        logic [31:0] v;
        if (ra >= RN[n] || (ZR[n] && ra == 0)) return 32'h0;
        v = mreg[n][ra];
        if (BYP[n])
            for (int k = 0; k < NW[n]; k++)
                if (commits(n, k) && s_waddr[n][k] == ra) v = s_wdata[n][k];
        return v;
    endfunction

    function automatic logic [31:0] exp_rbusy(int n, int p);
        int ra = s_raddr[n][p];
        bit b;
        if (ra >= RN[n] || (ZR[n] && ra == 0)) return 32'h0;
        b = mbusy[n][ra];
        if (BYP[n])
            for (int k = 0; k < NW[n]; k++)
                if (commits(n, k) && s_waddr[n][k] == ra) b = 1'b0;
        return {31'b0, b};
    endfunction

    function automatic logic [31:0] exp_busy(int n);
        logic [31:0] v = '0;
        for (int i = 0; i < RN[n]; i++) v[i] = mbusy[n][i];
        return v;
    endfunction

    function automatic logic [31:0] got_rdata(int n, int p);
        return (n == 0) ? a_rdata[p*32 +: 32] : b_rdata[p*32 +: 32];
    endfunction

    function automatic logic [31:0] got_rbusy(int n, int p);
        return (n == 0) ? {31'b0, a_rbusy[p]} : {31'b0, b_rbusy[p]};
    endfunction

    function automatic logic [31:0] got_busy(int n);
        return (n == 0) ? 32'(a_busy) : 32'(b_busy);
    endfunction

    // Advance the model by one clock edge. Writes apply in port order, so the last one wins.
    // Each write clears busy on its register. Sets are applied after clears, so a set wins.
    task automatic model_clock();
        for (int n = 0; n < 2; n++) begin
            if (s_rst) begin
                for (int i = 0; i < 32; i++) begin
                    mreg[n][i]  = '0;
                    mbusy[n][i] = 1'b0;
                end
            end else begin
                for (int k = 0; k < NW[n]; k++) begin
                    if (commits(n, k)) begin
                        mreg[n][s_waddr[n][k]]  = s_wdata[n][k];
                        mbusy[n][s_waddr[n][k]] = 1'b0;
                    end
                end
                if (s_set_en[n] && s_set_addr[n] < RN[n] && !(ZR[n] && s_set_addr[n] == 0))
                    mbusy[n][s_set_addr[n]] = 1'b1;
            end
        end
    endtask

    // Called at a falling edge with inputs applied. It compares every output against
    // the model, then crosses one rising edge.
    task automatic do_cycle();
        #1;
        if (mvalid) begin
            for (int n = 0; n < 2; n++) begin
                for (int p = 0; p < NR[n]; p++) begin
                    check($sformatf("rdata i%0d p%0d", n, p), got_rdata(n, p), exp_rdata(n, p));
                    check($sformatf("rbusy i%0d p%0d", n, p), got_rbusy(n, p), exp_rbusy(n, p));
                end
                check($sformatf("busy i%0d", n), got_busy(n), exp_busy(n));
            end
        end
        @(posedge clk);
        model_clock();
        if (s_rst) mvalid = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        s_rst = 1'b1;
        @(negedge clk);
        do_cycle();
        do_cycle();

        // Read after reset.
        clear_inputs();
        s_raddr[0][0] = 5; s_raddr[0][1] = 0;
        #1;
        check("rst rd5", got_rdata(0, 0), 32'h0);
        check("rst rd0", got_rdata(0, 1), 32'h0);
        check("rst busy", got_busy(0), 32'h0);
        check("rst rbusy", got_rbusy(0, 0), 32'h0);
        do_cycle();

        // No-bypass instance: the write becomes visible in the next cycle.
        clear_inputs();
        s_wen[1][0] = 1'b1; s_waddr[1][0] = 5; s_wdata[1][0] = 32'hDEADBEEF; s_raddr[1][0] = 5;
        #1;
        check("nobyp same cycle", got_rdata(1, 0), 32'h0);
        do_cycle();
        clear_inputs();
        s_raddr[1][0] = 5;
        #1;
        check("nobyp next cycle", got_rdata(1, 0), 32'hDEADBEEF);
        do_cycle();

        // x0 is constant on inst 0 and writable on inst 1.
        clear_inputs();
        s_wen[0][0] = 1'b1; s_waddr[0][0] = 0; s_wdata[0][0] = 32'h1234;
        s_wen[1][0] = 1'b1; s_waddr[1][0] = 0; s_wdata[1][0] = 32'h1234;
        #1;
        check("x0 no bypass", got_rdata(0, 0), 32'h0);
        do_cycle();
        clear_inputs();
        #1;
        check("x0 stays 0", got_rdata(0, 0), 32'h0);
        check("r0 writable", got_rdata(1, 0), 32'h1234);
        do_cycle();

        // Two ports write the same register: the higher-index port wins.
        clear_inputs();
        s_wen[0][0] = 1'b1; s_waddr[0][0] = 7; s_wdata[0][0] = 32'h11;
        s_wen[0][1] = 1'b1; s_waddr[0][1] = 7; s_wdata[0][1] = 32'h22;
        s_raddr[0][0] = 7;
        #1;
        check("collide bypass", got_rdata(0, 0), 32'h22);
        do_cycle();
        clear_inputs();
        s_raddr[0][0] = 7;
        #1;
        check("collide stored", got_rdata(0, 0), 32'h22);
        do_cycle();

        // Scoreboard set, clear by write, and set winning over clear.
        clear_inputs();
        s_set_en[0] = 1'b1; s_set_addr[0] = 3;
        do_cycle();
        clear_inputs();
        s_raddr[0][0] = 3;
        #1;
        check("set busy3", {31'b0, a_busy[3]}, 32'h1);
        check("set rbusy3", got_rbusy(0, 0), 32'h1);
        do_cycle();
        clear_inputs();
        s_wen[0][0] = 1'b1; s_waddr[0][0] = 3; s_wdata[0][0] = 32'h55; s_raddr[0][0] = 3;
        #1;
        check("wr rbusy drop", got_rbusy(0, 0), 32'h0);
        check("wr fwd 55", got_rdata(0, 0), 32'h55);
        do_cycle();
        clear_inputs();
        s_raddr[0][0] = 3;
        #1;
        check("clr busy3", {31'b0, a_busy[3]}, 32'h0);
        do_cycle();
        clear_inputs();
        s_set_en[0] = 1'b1; s_set_addr[0] = 3;
        s_wen[0][1] = 1'b1; s_waddr[0][1] = 3; s_wdata[0][1] = 32'h66;
        do_cycle();
        clear_inputs();
        s_raddr[0][0] = 3;
        #1;
        check("set beats clr", {31'b0, a_busy[3]}, 32'h1);
        check("set beats clr rbusy", got_rbusy(0, 0), 32'h1);
        do_cycle();

        // Top valid register on both instances.
        clear_inputs();
        s_wen[0][0] = 1'b1; s_waddr[0][0] = 19; s_wdata[0][0] = 32'hA5A5A5A5;
        s_wen[1][0] = 1'b1; s_waddr[1][0] = 15; s_wdata[1][0] = 32'hA5A5A5A5;
        do_cycle();
        clear_inputs();
        s_raddr[0][0] = 19; s_raddr[1][0] = 15;
        #1;
        check("top reg a", got_rdata(0, 0), 32'hA5A5A5A5);
        check("top reg b", got_rdata(1, 0), 32'hA5A5A5A5);
        do_cycle();

        // Out-of-range address: write, set and read are all ignored. A set on x0 is ignored too.
        clear_inputs();
        s_wen[0][0] = 1'b1; s_waddr[0][0] = 20; s_wdata[0][0] = 32'hFFFFFFFF;
        s_set_en[0] = 1'b1; s_set_addr[0] = 20;
        s_raddr[0][0] = 20; s_raddr[0][1] = 31;
        #1;
        check("oob rdata", got_rdata(0, 0), 32'h0);
        check("oob rbusy", got_rbusy(0, 0), 32'h0);
        check("oob rdata31", got_rdata(0, 1), 32'h0);
        do_cycle();
        clear_inputs();
        s_set_en[0] = 1'b1; s_set_addr[0] = 0;
        s_raddr[0][0] = 20;
        #1;
        check("oob set ignored", got_busy(0), 32'h8);
        do_cycle();
        clear_inputs();
        #1;
        check("x0 never busy", got_busy(0), 32'h8);
        do_cycle();

        // Reset in the middle of operation, with a write in the same cycle.
        clear_inputs();
        s_wen[0][0] = 1'b1; s_waddr[0][0] = 4; s_wdata[0][0] = 32'h99;
        s_set_en[0] = 1'b1; s_set_addr[0] = 4;
        do_cycle();
        clear_inputs();
        s_raddr[0][0] = 4;
        #1;
        check("pre-rst reg4", got_rdata(0, 0), 32'h99);
        check("pre-rst busy4", {31'b0, a_busy[4]}, 32'h1);
        do_cycle();
        clear_inputs();
        s_rst = 1'b1;
        s_wen[0][0] = 1'b1; s_waddr[0][0] = 4; s_wdata[0][0] = 32'h77; s_raddr[0][0] = 4;
        #1;
        check("rst no bypass", got_rdata(0, 0), 32'h99);
        do_cycle();
        clear_inputs();
        s_raddr[0][0] = 4;
        #1;
        check("post-rst reg4", got_rdata(0, 0), 32'h0);
        check("post-rst busy", got_busy(0), 32'h0);
        do_cycle();

        // Random traffic. Addresses are biased to the low registers so that
        // collisions and hazards occur often.
        for (int c = 0; c < 600; c++) begin
            clear_inputs();
            s_rst = ($urandom_range(0, 59) == 0);
            for (int n = 0; n < 2; n++) begin
                for (int p = 0; p < NR[n]; p++)
                    s_raddr[n][p] = $urandom_range(0, 1) ? $urandom_range(0, 7)
                                                         : $urandom_range(0, (1 << AW[n]) - 1);
                for (int k = 0; k < NW[n]; k++) begin
                    s_wen[n][k]   = $urandom_range(0, 1);
                    s_waddr[n][k] = $urandom_range(0, 1) ? $urandom_range(0, 7)
                                                         : $urandom_range(0, (1 << AW[n]) - 1);
                    s_wdata[n][k] = $urandom;
                end
                s_set_en[n]   = $urandom_range(0, 1);
                s_set_addr[n] = $urandom_range(0, 1) ? $urandom_range(0, 7)
                                                     : $urandom_range(0, (1 << AW[n]) - 1);
            end
            do_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
